// File: rtl/rgb_blend_pipe.sv
// rgb_blend_pipe: two-stage per-channel RGB multiply/blend with valid/ready flow control and sideband tag
module rgb_blend_pipe #(
  parameter int WIDTH     = 24,
  parameter int Q_BITS    = 12,
  parameter int RGB_WIDTH = 8,
  parameter int NUM_CH    = 3,
  parameter int TAG_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    mode_in,
  input  logic [NUM_CH*RGB_WIDTH-1:0]   a_in,
  input  logic [NUM_CH*RGB_WIDTH-1:0]   b_in,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*WIDTH-1:0]       result_out,
  output logic [TAG_WIDTH-1:0]          tag_out
);
  localparam int R = RGB_WIDTH;
  localparam logic [R-1:0] MAX = '1;
  localparam logic [2*R-1:0] MAX2 = {{R{1'b0}}, MAX};

  if (WIDTH < Q_BITS + RGB_WIDTH + 1) begin : g_bad_params
    $error("rgb_blend_pipe: WIDTH must be >= Q_BITS+RGB_WIDTH+1");
  end

  logic                     s1_valid, s2_valid, s2_load, accept;
  logic [1:0]               s1_mode;
  logic [TAG_WIDTH-1:0]     s1_tag;
  logic [NUM_CH*2*R-1:0]    p_d, s1_p;
  logic [NUM_CH*WIDTH-1:0]  res_d;

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !rst && (!s1_valid || s2_load);
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [2*R-1:0] a, b, p;
    logic [2*R:0]   x, y;
    logic [R-1:0]   n, c;
    assign a = {{R{1'b0}}, a_in[g*R +: R]};
    assign b = {{R{1'b0}}, b_in[g*R +: R]};
    assign p_d[g*2*R +: 2*R] = mode_in == 2'd2 ? (MAX2 - a) * (MAX2 - b) :
                               mode_in == 2'd3 ? a : a * b;
    assign p = s1_p[g*2*R +: 2*R];
    // exact round(p/MAX): add half, then fold the high part back in
    assign x = {1'b0, p} + (2*R+1)'(1 << (R-1));
    assign y = x + (x >> R);
    assign n = R'(y >> R);
    assign c = s1_mode == 2'd0 ? p[2*R-1:R] :
               s1_mode == 2'd1 ? n :
               s1_mode == 2'd2 ? MAX - n : p[R-1:0];
    assign res_d[g*WIDTH +: WIDTH] = {{(WIDTH-R-Q_BITS){1'b0}}, c, {Q_BITS{1'b0}}};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_mode    <= '0;
      s1_tag     <= '0;
      s1_p       <= '0;
      result_out <= '0;
      tag_out    <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_load);
      s2_valid <= s2_load || (s2_valid && !out_ready);
      if (accept) begin
        s1_p    <= p_d;
        s1_mode <= mode_in;
        s1_tag  <= tag_in;
      end
      if (s2_load) begin
        result_out <= res_d;
        tag_out    <= s1_tag;
      end
    end
endmodule
